max_pool_2x2: RTL and testbench

Max-pooling stage directly downstream of the pooling line-buffer controller.
- Consumes the 2x2 window stream on `pool_input_data` / `pool_input_data_valid`.
- Applies stride-2 column decimation and reduces each kept window to its signed maximum.
- Emits one pooled fixed-point value per kept window to the next layer.
- Ships with an optional ReLU clamp.

---
 rtl/max_pool_2x2.sv | 100 ++++++++++
 tb/tb_max_pool_2x2.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/max_pool_2x2.sv
// 2x2 stride-2 signed max-pool stage; optional ReLU clamp on the result when MAX_POOL_RELU_EN is defined.
// Latency: a kept window's pooled value appears two rising edges after the window is accepted.
// Backpressure: none; accepts one window per cycle and never stalls.
module max_pool_2x2 #(
   parameter int INTEGER_BITS     = 9,
   parameter int FIXED_POINT_BITS = 4,
   parameter int LINE_WIDTH       = 512
) (
   input  logic                                            i_clk,
   input  logic                                            i_rst,
   input  logic [4*(INTEGER_BITS+FIXED_POINT_BITS)-1:0]    pool_input_data,
   input  logic                                            pool_input_data_valid,
   output logic [INTEGER_BITS+FIXED_POINT_BITS-1:0]        o_pooled_data,
   output logic                                            o_pooled_data_valid,
   output logic                                            o_row_done
);

   localparam int W  = INTEGER_BITS + FIXED_POINT_BITS;
   localparam int CW = $clog2(LINE_WIDTH);

   localparam logic [CW-1:0] COL_LAST      = CW'(LINE_WIDTH - 1);
   localparam logic [CW-1:0] COL_LAST_KEPT = CW'(LINE_WIDTH - 2);

   // Signed maximum; on a tie the left operand (earlier column / row0) is returned.
   function automatic logic [W-1:0] smax(input logic [W-1:0] a, input logic [W-1:0] b);
      return ($signed(a) >= $signed(b)) ? a : b;
   endfunction

   logic [CW-1:0] col_q, col_d;
   logic [W-1:0]  m0_q, m0_d;
   logic [W-1:0]  m1_q, m1_d;
   logic          v1_q, v1_d;
   logic          last1_q, last1_d;
   logic [W-1:0]  out_q, out_d;
   logic          v2_q, v2_d;
   logic          row_done_q, row_done_d;

   logic [W-1:0]  r0_n, r0_n1, r1_n, r1_n1;
   logic          kept;
   logic [W-1:0]  max2;
   logic [W-1:0]  result;

   always_comb begin
      r0_n  = pool_input_data[4*W-1:3*W];
      r0_n1 = pool_input_data[3*W-1:2*W];
      r1_n  = pool_input_data[2*W-1:W];
      r1_n1 = pool_input_data[W-1:0];

      // Parity advances per valid window, not per cycle, so gaps keep the stride intact.
      kept  = pool_input_data_valid & ~col_q[0];

      col_d = col_q;
      if (pool_input_data_valid) begin
         col_d = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
      end

      v1_d    = kept;
      last1_d = kept & (col_q == COL_LAST_KEPT);
      m0_d    = kept ? smax(r0_n, r0_n1) : m0_q;
      m1_d    = kept ? smax(r1_n, r1_n1) : m1_q;

      max2 = smax(m0_q, m1_q);
`ifdef MAX_POOL_RELU_EN
      result = max2[W-1] ? '0 : max2;
`else
      result = max2;
`endif

      v2_d       = v1_q;
      row_done_d = v1_q & last1_q;
      out_d      = v1_q ? result : out_q;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         col_q      <= '0;
         m0_q       <= '0;
         m1_q       <= '0;
         v1_q       <= 1'b0;
         last1_q    <= 1'b0;
         out_q      <= '0;
         v2_q       <= 1'b0;
         row_done_q <= 1'b0;
      end else begin
         col_q      <= col_d;
         m0_q       <= m0_d;
         m1_q       <= m1_d;
         v1_q       <= v1_d;
         last1_q    <= last1_d;
         out_q      <= out_d;
         v2_q       <= v2_d;
         row_done_q <= row_done_d;
      end
   end

   assign o_pooled_data       = out_q;
   assign o_pooled_data_valid = v2_q;
   assign o_row_done          = row_done_q;

endmodule

// File: tb/tb_max_pool_2x2.sv
// Self-checking bench for max_pool_2x2 against a queue-based reference model.
module tb_max_pool_2x2;

   localparam int W  = 13;
   localparam int L  = 512;
   localparam int NW = 2 * L;

   logic              clk;
   logic              rst;
   logic [4*W-1:0]    in_dat;
   logic              in_vld;
   logic [W-1:0]      o_dat;
   logic              o_vld;
   logic              o_row_done;

   int checks = 0;
   int errors = 0;

   logic [W-1:0] obs_dat_q[$];
   bit           obs_rd_q[$];
   int           orphan_cnt = 0;

   logic [4*W-1:0] stream_a [0:NW-1];
   logic [W-1:0]   exp_dat_q[$];
   bit             exp_rd_q[$];

   max_pool_2x2 #(
      .INTEGER_BITS(9),
      .FIXED_POINT_BITS(4),
      .LINE_WIDTH(L)
   ) dut (
      .i_clk(clk),
      .i_rst(rst),
      .pool_input_data(in_dat),
      .pool_input_data_valid(in_vld),
      .o_pooled_data(o_dat),
      .o_pooled_data_valid(o_vld),
      .o_row_done(o_row_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always begin
      @(posedge clk);
      #1;
      if (o_vld === 1'b1) begin
         obs_dat_q.push_back(o_dat);
         obs_rd_q.push_back(o_row_done);
      end
      if (o_row_done === 1'b1 && o_vld !== 1'b1) orphan_cnt++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, time=%0t limit=2000000", $time);
      $fatal(1, "watchdog");
   end

   // Reference: maximum of the four signed values, optionally clamped at zero.
   function automatic logic [W-1:0] pool_ref(input logic [4*W-1:0] w);
      int best;
      int v;
      best = -(1 << 30);
      for (int k = 0; k < 4; k++) begin
         v = int'($signed(w[k*W +: W]));
         if (v > best) best = v;
      end
`ifdef MAX_POOL_RELU_EN
      if (best < 0) best = 0;
`endif
      return W'(best);
   endfunction

   // Every even-indexed valid window after reset produces one output; the last of each row pair flags row_done.
   task automatic build_expected(input int n);
      int j;
      exp_dat_q.delete();
      exp_rd_q.delete();
      j = 0;
      for (int i = 0; i < n; i++) begin
         if (i % 2 == 0) begin
            exp_dat_q.push_back(pool_ref(stream_a[i]));
            exp_rd_q.push_back((j % (L/2)) == (L/2 - 1));
            j++;
         end
      end
   endtask

   task automatic send(input logic [4*W-1:0] w, input logic v);
      in_dat = w;
      in_vld = v;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst    = 1'b1;
      in_vld = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      obs_dat_q.delete();
      obs_rd_q.delete();
   endtask

   function automatic logic [4*W-1:0] rand_win();
      return {W'($urandom), W'($urandom), W'($urandom), W'($urandom)};
   endfunction

   task automatic compare_stream(input string tag);
      int n;
      checks++;
      if (obs_dat_q.size() != exp_dat_q.size()) begin
         errors++;
         $display("FAIL %s_count: got %0d outputs, expected %0d", tag, obs_dat_q.size(), exp_dat_q.size());
      end
      n = (obs_dat_q.size() < exp_dat_q.size()) ? obs_dat_q.size() : exp_dat_q.size();
      for (int i = 0; i < n; i++) begin
         checks++;
         if (obs_dat_q[i] !== exp_dat_q[i] || obs_rd_q[i] !== exp_rd_q[i]) begin
            errors++;
            $display("FAIL %s_out[%0d]: got dat=%h row_done=%0b, expected dat=%h row_done=%0b",
                     tag, i, obs_dat_q[i], obs_rd_q[i], exp_dat_q[i], exp_rd_q[i]);
         end
      end
      checks++;
      if (orphan_cnt != 0) begin
         errors++;
         $display("FAIL %s_orphan_row_done: got %0d pulses without valid, expected 0", tag, orphan_cnt);
      end
   endtask

   task automatic test_reset();
      rst    = 1'b1;
      in_vld = 1'b0;
      in_dat = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if (o_dat !== '0 || o_vld !== 1'b0 || o_row_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle[%0d]: got dat=%h vld=%b rd=%b, expected 0 0 0", i, o_dat, o_vld, o_row_done);
         end
      end
   endtask

   task automatic expect_pulse(input string tag, input logic [W-1:0] exp);
      @(posedge clk);
      @(negedge clk);
      in_vld = 1'b0;
      for (int c = 0; c < 2; c++) begin
         checks++;
         if (o_vld !== (c == 1)) begin
            errors++;
            $display("FAIL %s_latency[%0d]: got vld=%b, expected %b", tag, c + 1, o_vld, (c == 1));
         end
         if (c == 0) @(negedge clk);
      end
      checks++;
      if (o_dat !== exp) begin
         errors++;
         $display("FAIL %s_value: got %h, expected %h", tag, o_dat, exp);
      end
      @(negedge clk);
      checks++;
      if (o_vld !== 1'b0) begin
         errors++;
         $display("FAIL %s_one_cycle: got vld=%b, expected 0", tag, o_vld);
      end
   endtask

   task automatic test_basic_latency();
      in_dat = {13'h0010, 13'h0030, 13'h0020, 13'h0008};
      in_vld = 1'b1;
      expect_pulse("basic", 13'h0030);
      send({13'h0010, 13'h0030, 13'h0020, 13'h0008}, 1'b1);
      for (int i = 0; i < 4; i++) begin
         send(rand_win(), 1'b0);
         checks++;
         if (o_vld !== 1'b0) begin
            errors++;
            $display("FAIL odd_col_dropped[%0d]: got vld=%b, expected 0", i, o_vld);
         end
      end
   endtask

   task automatic test_signed();
      logic [W-1:0] exp;
`ifdef MAX_POOL_RELU_EN
      exp = 13'h0000;
`else
      exp = 13'h1FF8;
`endif
      in_dat = {13'h1FF0, 13'h1FE0, 13'h1FC0, 13'h1FF8};
      in_vld = 1'b1;
      expect_pulse("signed", exp);
   endtask

   task automatic test_full_row();
      for (int i = 0; i < NW; i++) begin
         stream_a[i] = rand_win();
         stream_a[i][2*W-1:W] = W'(i % L);
      end
      build_expected(NW);
      do_reset();
      orphan_cnt = 0;
      for (int i = 0; i < NW; i++) send(stream_a[i], 1'b1);
      for (int i = 0; i < 5; i++) send(rand_win(), 1'b0);
      compare_stream("full_row");
   endtask

   task automatic test_gapped();
      do_reset();
      orphan_cnt = 0;
      for (int i = 0; i < NW; i++) begin
         while ($urandom_range(1, 0) == 1) send(rand_win(), 1'b0);
         send(stream_a[i], 1'b1);
      end
      for (int i = 0; i < 5; i++) send(rand_win(), 1'b0);
      compare_stream("gapped");
   endtask

   task automatic test_mid_reset();
      do_reset();
      orphan_cnt = 0;
      for (int i = 0; i < 37; i++) send(rand_win(), 1'b1);
      obs_dat_q.delete();
      obs_rd_q.delete();
      rst    = 1'b1;
      in_vld = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         stream_a[i] = rand_win();
         send(stream_a[i], 1'b1);
      end
      for (int i = 0; i < 6; i++) send(rand_win(), 1'b0);
      build_expected(4);
      compare_stream("mid_reset");
   endtask

   initial begin
      test_reset();
      test_basic_latency();
      test_signed();
      test_full_row();
      test_gapped();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
